adder_pipe: RTL

- Parametrised, pipelined successor to the team's single-cycle registered 8-bit adder.
- Adds or subtracts two WIDTH-bit operands through a carry chain split across STAGES register slices.
- Optional unsigned saturation.
- Full valid/ready handshakes on input and output, so it drops into streaming datapaths between producer and consumer blocks.

---
 rtl/adder_pipe_if.sv | 35 +++
 rtl/adder_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pipe_if
//  Description : Streaming bus for adder_pipe. It carries the operand beat
//                (in_valid/in_ready, in0, in1, sub, sat) and the result beat
//                (out_valid/out_ready, out, carry, ovf).
//                master = producer/consumer side, slave = adder side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adder_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             ovf;

    modport master (
        output in_valid, in0, in1, sub, sat, out_ready,
        input  in_ready, out_valid, out, carry, ovf
    );

    modport slave (
        input  in_valid, in0, in1, sub, sat, out_ready,
        output in_ready, out_valid, out, carry, ovf
    );
endinterface
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pipe
//  Description : Pipelined add/subtract of two WIDTH-bit operands. The carry
//                chain is cut into STAGES equal slices with a register after
//                each slice. Unsigned saturation is optional. Both sides use
//                a valid/ready handshake.
//  Ports       : clk - rising-edge clock
//                rst - asynchronous active-high reset
//                bus - adder_pipe_if.slave (operand beat in, result beat out)
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    adder_pipe_if.slave bus
);
    localparam int c_w    = WIDTH / STAGES;                 // slice width
    localparam int c_last = STAGES - 1;                     // output stage index
    localparam int c_nreg = (STAGES > 1) ? STAGES - 1 : 1;  // inter-stage regs
    localparam logic [WIDTH-1:0] c_ones = '1;

    generate
        if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
            $error("adder_pipe: WIDTH must be a multiple of STAGES, and STAGES must be at least 1");
        end
    endgenerate

    // Inputs presented to each stage's slice adder.
    logic             w_vld   [STAGES];
    logic [WIDTH-1:0] w_a     [STAGES];
    logic [WIDTH-1:0] w_b     [STAGES];  // effective B (already inverted for sub)
    logic [WIDTH-1:0] w_sum   [STAGES];  // lower result slices done so far
    logic             w_cy    [STAGES];
    logic             w_sub   [STAGES];
    logic             w_sat   [STAGES];
    // Outputs of each stage's slice adder.
    logic [WIDTH-1:0] w_sum_n [STAGES];
    logic             w_cy_n  [STAGES];

    // Registers between stage k and stage k+1 (k < STAGES-1).
    logic             r_vld [c_nreg];
    logic [WIDTH-1:0] r_a   [c_nreg];
    logic [WIDTH-1:0] r_b   [c_nreg];
    logic [WIDTH-1:0] r_sum [c_nreg];
    logic             r_cy  [c_nreg];
    logic             r_sub [c_nreg];
    logic             r_sat [c_nreg];

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic             r_ovf;

    // A held result freezes the whole pipe, bubbles included.
    logic w_stall;
    assign w_stall      = r_out_valid && !bus.out_ready;
    assign bus.in_ready = !w_stall;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam logic [WIDTH-1:0] c_mask = (c_ones >> (WIDTH - c_w)) << (k * c_w);
            logic [c_w:0] w_slice;

            if (k == 0) begin : g_first
                // Subtraction is A + ~B + 1: invert B and feed sub in as the carry.
                assign w_vld[k] = bus.in_valid && !w_stall;
                assign w_a[k]   = bus.in0;
                assign w_b[k]   = bus.sub ? ~bus.in1 : bus.in1;
                assign w_sum[k] = '0;
                assign w_cy[k]  = bus.sub;
                assign w_sub[k] = bus.sub;
                assign w_sat[k] = bus.sat;
            end else begin : g_next
                assign w_vld[k] = r_vld[k-1];
                assign w_a[k]   = r_a[k-1];
                assign w_b[k]   = r_b[k-1];
                assign w_sum[k] = r_sum[k-1];
                assign w_cy[k]  = r_cy[k-1];
                assign w_sub[k] = r_sub[k-1];
                assign w_sat[k] = r_sat[k-1];
            end

            assign w_slice = {1'b0, w_a[k][k*c_w +: c_w]}
                           + {1'b0, w_b[k][k*c_w +: c_w]}
                           + {{c_w{1'b0}}, w_cy[k]};
            // Put this stage's slice into the partial sum and keep the lower slices.
            assign w_sum_n[k] = (w_sum[k] & ~c_mask)
                              | (WIDTH'(w_slice[c_w-1:0]) << (k * c_w));
            assign w_cy_n[k]  = w_slice[c_w];
        end
    endgenerate

    // Result and flags of the final stage.
    logic [WIDTH-1:0] w_raw;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;

    assign w_raw  = w_sum_n[c_last];
    assign w_cout = w_cy_n[c_last];
    assign w_ovf  = (w_a[c_last][WIDTH-1] == w_b[c_last][WIDTH-1])
                 && (w_raw[WIDTH-1] != w_a[c_last][WIDTH-1]);

    // Saturation changes only the data. carry and ovf still describe the raw sum.
    always_comb begin
        w_res = w_raw;
        if (w_sat[c_last]) begin
            if (!w_sub[c_last] && w_cout) begin
                w_res = '1;
            end else if (w_sub[c_last] && !w_cout) begin
                w_res = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_nreg; i++) begin
                r_vld[i] <= 1'b0;
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_sum[i] <= '0;
                r_cy[i]  <= 1'b0;
                r_sub[i] <= 1'b0;
                r_sat[i] <= 1'b0;
            end
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (!w_stall) begin
            for (int i = 0; i < c_last; i++) begin
                r_vld[i] <= w_vld[i];
                r_a[i]   <= w_a[i];
                r_b[i]   <= w_b[i];
                r_sum[i] <= w_sum_n[i];
                r_cy[i]  <= w_cy_n[i];
                r_sub[i] <= w_sub[i];
                r_sat[i] <= w_sat[i];
            end
            r_out_valid <= w_vld[c_last];
            // A bubble leaves the last result on out/carry/ovf.
            if (w_vld[c_last]) begin
                r_out   <= w_res;
                r_carry <= w_cout;
                r_ovf   <= w_ovf;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.carry     = r_carry;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire
